imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
- Shares one backing memory port between the instruction-fetch requester (I, read-only) and the memory-stage requester (D, read/write).
- Sits between the fetch/memory pipeline stages and the single stall-style main memory.
- Grants one transaction at a time and provides D priority with an anti-starvation limit for I.
- Returns stall/done/data per requester and detects misaligned addresses and memory timeouts.

Parameters:
- TIMEOUT, 64, cycles allowed from issue to mem_done before error abort (must be >= 2).
- STARVE_MAX, 2, consecutive D grants allowed while I is pending before I is forced next.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_rd  in  1  fetch read request; held until i_done.
- i_addr  in  16  fetch address.
- i_stall  out  1  fetch request pending, not yet done.
- i_done  out  1  one-cycle pulse; i_data valid this cycle.
- i_data  out  16  fetch read data, held until next i_done.
- d_rd  in  1  data read request; held until d_done.
- d_wr  in  1  data write request; held until d_done.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_stall  out  1  data request pending, not yet done.
- d_done  out  1  one-cycle pulse; d_data valid on reads.
- d_data  out  16  data read result, held until next d_done.
- mem_rd  out  1  backing memory read strobe, held through transaction.
- mem_wr  out  1  backing memory write strobe, held through transaction.
- mem_addr  out  16  registered address to memory.
- mem_wdata  out  16  registered write data to memory.
- mem_rdata  in  16  memory read data, valid with mem_done.
- mem_done  in  1  memory completion pulse.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0, including i_data and d_data.
  - Starvation counter and timeout counter cleared.
- Reset mid-transaction:
  - Aborts immediately; no done pulse.
  - Memory strobes drop asynchronously.
- Request validity:
  - D request = d_rd | d_wr.
  - d_rd & d_wr both 1 is illegal: err pulses and a write is performed (write wins).
- Stall outputs (combinational):
  - i_stall = i_rd & ~i_done.
  - d_stall = (d_rd|d_wr) & ~d_done.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE arbitration:
  - Only D requesting -> BUSY_D.
  - Only I requesting -> BUSY_I.
  - Both requesting: D wins unless starve_cnt == STARVE_MAX, in which case I wins.
  - starve_cnt increments on each D grant made while I is pending, and clears on any I grant.
- Issue:
  - On the grant edge, mem_addr, mem_wdata and the strobe are registered.
  - Strobes are visible the cycle after the request is first seen in IDLE.
  - Timeout counter loads 0.
- BUSY_x:
  - Strobes held constant.
  - Counter increments each cycle.
  - mem_done=1: capture mem_rdata (reads only) -> RESP.
  - Counter reaches TIMEOUT-1 with no mem_done: drop strobes, err=1 next cycle, the requester's done pulses with data=16'h0000, -> IDLE.
- RESP (one cycle):
  - Strobes 0.
  - Granted requester's done=1 with captured data.
  - Next state IDLE.
  - The earliest new grant is the cycle after RESP, giving a one-cycle bubble between transactions.
- Minimum latency: request at cycle N, strobe at N+1, mem_done at N+1, done at N+2.
- Misaligned address (bit0=1) seen in IDLE:
  - Not forwarded to memory.
  - err and the requester's done pulse next cycle; data = 0.
  - Arbitration priority still applies.
- Request withdrawn mid-transaction:
  - The transaction completes normally.
  - The done pulse is still generated; the requester ignores it.
- mem_done while IDLE or RESP: ignored; no error.
- i_data/d_data change only on their own done pulse.

Test Plan:
- Reset then I read 0x0010 alone, memory returns 0xABCD with 1-cycle latency -> mem_rd=1 at N+1, mem_addr=0x0010, i_done at N+2, i_data=0xABCD, i_stall high N..N+1.
- D write 0x0100<-0x1234 and I read 0x0002 raised together -> D granted first (mem_wr=1, mem_wdata=0x1234), d_done; then I served after the 1-cycle bubble, i_done.
- I held pending while D requests continuously, STARVE_MAX=2 -> grant order D, D, I, D, D, I; starve_cnt clears on each I grant.
- D read 0x0200 and memory never asserts mem_done, TIMEOUT=64 -> strobe held 64 cycles, then dropped; err and d_done pulse together, d_data=0x0000, FSM returns to IDLE.
- I read 0x0003 (odd) -> no mem_rd asserted; err and i_done pulse the next cycle, i_data=0.
- rst driven low 2 cycles into a BUSY_D transaction -> mem_wr/mem_rd fall immediately, no d_done; after rst=1, a new I read completes normally.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one stall-style memory port between instruction fetch (read-only) and the memory stage (read/write).
// The memory stage has priority, but after STARVE_MAX consecutive D grants with fetch waiting, fetch goes next.
module imem_dmem_arbiter #(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic        i_stall,
  output logic        i_done,
  output logic [15:0] i_data,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_stall,
  output logic        d_done,
  output logic [15:0] d_data,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_RESP} state_t;

  state_t          r_state, w_next;
  logic            r_gnt_i, r_err, r_mem_rd, r_mem_wr;
  logic [15:0]     r_mem_addr, r_mem_wdata, r_i_data, r_d_data;
  logic [SW-1:0]   r_starve;
  logic [TW-1:0]   r_tcnt;
  logic            w_d_req, w_any_req, w_pick_i, w_timeout;
  logic [15:0]     w_addr;

  assign w_d_req   = d_rd | d_wr;
  assign w_any_req = i_rd | w_d_req;
  assign w_pick_i  = i_rd & (~w_d_req | (r_starve == SW'(STARVE_MAX)));
  assign w_addr    = w_pick_i ? i_addr : d_addr;
  assign w_timeout = (r_tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          if (w_addr[0])     w_next = S_RESP;
          else if (w_pick_i) w_next = S_BUSY_I;
          else               w_next = S_BUSY_D;
        end
      end
      S_BUSY_I, S_BUSY_D: if (mem_done || w_timeout) w_next = S_RESP;
      default:            w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_gnt_i     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_data    <= '0;
      r_d_data    <= '0;
      r_starve    <= '0;
      r_tcnt      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_i <= w_pick_i;
            r_tcnt  <= '0;
            if (w_pick_i)  r_starve <= '0;
            else if (i_rd) r_starve <= r_starve + SW'(1);
            if (w_addr[0]) begin
              // Misaligned: skip memory and answer with an error on the next cycle.
              r_err <= 1'b1;
              if (w_pick_i) r_i_data <= '0;
              else          r_d_data <= '0;
            end else begin
              r_err       <= ~w_pick_i & d_rd & d_wr;
              r_mem_addr  <= w_addr;
              r_mem_wdata <= w_pick_i ? '0 : d_wdata;
              r_mem_rd    <= w_pick_i | ~d_wr;
              r_mem_wr    <= ~w_pick_i & d_wr;
            end
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          r_tcnt <= r_tcnt + TW'(1);
          if (mem_done) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_gnt_i)       r_i_data <= mem_rdata;
            else if (r_mem_rd) r_d_data <= mem_rdata;
          end else if (w_timeout) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_err    <= 1'b1;
            if (r_gnt_i) r_i_data <= '0;
            else         r_d_data <= '0;
          end
        end
        default: r_err <= 1'b0;
      endcase
    end
  end

  assign i_done    = (r_state == S_RESP) & r_gnt_i;
  assign d_done    = (r_state == S_RESP) & ~r_gnt_i;
  assign err       = (r_state == S_RESP) & r_err;
  assign i_stall   = i_rd & ~i_done;
  assign d_stall   = w_d_req & ~d_done;
  assign i_data    = r_i_data;
  assign d_data    = r_d_data;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
